// File: rtl/adder_bist_pkg.sv
// Shared types and default sizing for the adder BIST controller.
package adder_bist_pkg;

    localparam int unsigned DEF_WIDTH         = 4;
    localparam int unsigned DEF_SETTLE_CYCLES = 1;
    localparam int unsigned DEF_FAIL_W        = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } bist_state_t;

endpackage

// File: rtl/bist_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module bist_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/adder_bist_ctrl.sv
// Exhaustive BIST sequencer for a WIDTH-bit adder: sweeps every {a,b,cin},
// waits for the adder to settle, and counts mismatching results.
module adder_bist_ctrl
    import adder_bist_pkg::*;
#(
    parameter int unsigned WIDTH         = DEF_WIDTH,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int unsigned FAIL_W        = DEF_FAIL_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [WIDTH-1:0]     a,
    output logic [WIDTH-1:0]     b,
    output logic                 cin,
    input  logic [WIDTH-1:0]     dut_sum,
    input  logic                 dut_cout,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [FAIL_W-1:0]    fail_count,
    output logic [2*WIDTH:0]     first_fail_idx
);

    localparam int unsigned IDX_W = 2 * WIDTH + 1;
    localparam int unsigned SUM_W = WIDTH + 1;
    localparam int unsigned CNT_W = 4;

    bist_state_t        state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   vec_q, vec_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   first_q, first_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               fail_clr;
    logic               fail_inc;
    logic [SUM_W-1:0]   expected;
    logic               mismatch;

    // Reference sum from the operands currently applied to the adder.
    always_comb begin
        expected = SUM_W'(vec_q[IDX_W-1 -: WIDTH]) + SUM_W'(vec_q[WIDTH:1]) + SUM_W'(vec_q[0]);
        mismatch = ({dut_cout, dut_sum} != expected);
    end

    // Next-state, sweep index, settle timer and result bookkeeping.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        vec_d    = vec_q;
        cnt_d    = cnt_q;
        first_d  = first_q;
        fail_clr = 1'b0;
        fail_inc = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_DRIVE;
                    idx_d    = '0;
                    first_d  = '0;
                    fail_clr = 1'b1;
                end
            end
            ST_DRIVE: begin
                vec_d   = idx_q;
                cnt_d   = '0;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CHECK: begin
                if (mismatch) begin
                    fail_inc = 1'b1;
                    if (fail_count == '0) begin
                        first_d = idx_q;
                    end
                end
                if (idx_q == '1) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_DRIVE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_DRIVE) || (state_d == ST_SETTLE) || (state_d == ST_CHECK);
        done_d = (state_d == ST_DONE);
        // The count cannot change once DONE is reached, so a pending increment decides pass.
        pass_d = done_d && (fail_count == '0) && !fail_inc;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            vec_q   <= '0;
            cnt_q   <= '0;
            first_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    bist_sat_counter #(
        .W (FAIL_W)
    ) u_fail_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (fail_clr),
        .inc   (fail_inc),
        .count (fail_count)
    );

    assign a              = vec_q[IDX_W-1 -: WIDTH];
    assign b              = vec_q[WIDTH:1];
    assign cin            = vec_q[0];
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign first_fail_idx = first_q;

endmodule

// File: tb/tb_adder_bist_ctrl.sv
// Randomized bench for adder_bist_ctrl with a cycle-level behavioural model.
module tb_adder_bist_ctrl;

    localparam int W   = 4;
    localparam int S   = 1;
    localparam int N   = 512;
    localparam int RUN = N * (S + 2);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        start_aux = 1'b0;

    // Main instance: W=4, S=1, 16-bit fail counter, programmable faulty adder.
    logic [3:0]  a, b, dut_sum;
    logic        cin, dut_cout, busy, done, pass;
    logic [15:0] fail_count;
    logic [8:0]  first_fail_idx;
    logic [4:0]  add_raw, add_out;
    int          fault_mode = 0;
    logic [4:0]  err_mask [N];

    // Aux instance 1: W=1, S=2, carry-out stuck at 0.
    logic [0:0]  a1, b1, sum1;
    logic        cin1, cout1, busy1, done1, pass1;
    logic [15:0] fc1;
    logic [2:0]  ffi1;

    // Aux instance 2: W=4, S=1, 4-bit fail counter, sum bit0 stuck at 0.
    logic [3:0]  a2, b2, sum2;
    logic        cin2, cout2, busy2, done2, pass2;
    logic [3:0]  fc2;
    logic [8:0]  ffi2;
    logic [4:0]  raw2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    adder_bist_ctrl #(.WIDTH(4), .SETTLE_CYCLES(1), .FAIL_W(16)) u_dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .dut_sum(dut_sum), .dut_cout(dut_cout), .busy(busy), .done(done), .pass(pass),
        .fail_count(fail_count), .first_fail_idx(first_fail_idx)
    );

    adder_bist_ctrl #(.WIDTH(1), .SETTLE_CYCLES(2), .FAIL_W(16)) u_w1 (
        .clk(clk), .rst(rst), .start(start_aux), .a(a1), .b(b1), .cin(cin1),
        .dut_sum(sum1), .dut_cout(cout1), .busy(busy1), .done(done1), .pass(pass1),
        .fail_count(fc1), .first_fail_idx(ffi1)
    );

    adder_bist_ctrl #(.WIDTH(4), .SETTLE_CYCLES(1), .FAIL_W(4)) u_f4 (
        .clk(clk), .rst(rst), .start(start_aux), .a(a2), .b(b2), .cin(cin2),
        .dut_sum(sum2), .dut_cout(cout2), .busy(busy2), .done(done2), .pass(pass2),
        .fail_count(fc2), .first_fail_idx(ffi2)
    );

    // Adders under test.
    always_comb begin
        add_raw = 5'(a) + 5'(b) + 5'(cin);
        case (fault_mode)
            1:       add_out = add_raw & 5'h1E;
            2:       add_out = add_raw ^ err_mask[{a, b, cin}];
            default: add_out = add_raw;
        endcase
        {dut_cout, dut_sum} = add_out;
    end

    assign sum1  = a1 ^ b1 ^ cin1;
    assign cout1 = 1'b0;
    assign raw2  = 5'(a2) + 5'(b2) + 5'(cin2);
    assign sum2  = raw2[3:0] & 4'hE;
    assign cout2 = raw2[4];

    // Behavioural model state: run flag, finished flag, cycle offset from first DRIVE.
    bit m_run = 0;
    bit m_fin = 0;
    int m_k = 0;
    int m_fails = 0;
    int m_first = 0;
    int m_vec = 0;

    function automatic bit faulty(input int v);
        int av, bv, cv;
        av = (v >> 5) & 15;
        bv = (v >> 1) & 15;
        cv = v & 1;
        case (fault_mode)
            1:       return ((av + bv + cv) % 2) == 1;
            2:       return err_mask[v] != 5'd0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_step();
        int v, p;
        if (rst) begin
            m_run = 0; m_fin = 0; m_k = 0; m_fails = 0; m_first = 0; m_vec = 0;
        end else if (!m_run) begin
            if (start) begin
                m_run = 1; m_fin = 0; m_k = 0; m_fails = 0; m_first = 0;
            end
        end else begin
            v = m_k / (S + 2);
            p = m_k % (S + 2);
            if (p == 0) m_vec = v;
            if (p == S + 1) begin
                if (faulty(v)) begin
                    if (m_fails == 0) m_first = v;
                    if (m_fails < 65535) m_fails++;
                end
                if (v == N - 1) begin
                    m_run = 0;
                    m_fin = 1;
                end
            end
            m_k++;
        end
    endtask

    // Per-cycle comparison of every main-instance output against the model.
    initial begin
        logic [8:0] ev;
        logic       ep;
        forever begin
            @(posedge clk);
            model_step();
            #1;
            ev = 9'(m_vec);
            ep = m_fin && (m_fails == 0);
            n_vec++;
            if ({a, b, cin} != ev || busy != m_run || done != m_fin || pass != ep ||
                fail_count != 16'(m_fails) || first_fail_idx != 9'(m_first)) begin
                n_err++;
                $display("FAIL cycle_cmp t=%0t got vec=%h busy=%b done=%b pass=%b fc=%0d ffi=%h want vec=%h busy=%b done=%b pass=%b fc=%0d ffi=%h",
                         $time, {a, b, cin}, busy, done, pass, fail_count, first_fail_idx,
                         ev, m_run, m_fin, ep, m_fails, 9'(m_first));
            end
        end
    end

    task automatic check_val(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Start a run, optionally holding start as a level or poking it mid-run; count cycles to done.
    task automatic run_once(input int hold, input bit inject, input bit aux, output int cyc);
        bit fin;
        fin = 0;
        @(negedge clk);
        start = 1'b1;
        if (aux) start_aux = 1'b1;
        @(posedge clk);
        #1;
        start_aux = 1'b0;
        cyc = 0;
        while (!fin && cyc < 4000) begin
            if (cyc < hold - 1) start = 1'b1;
            else start = inject && (cyc >= 10) && (cyc <= 1400) && ($urandom_range(0, 47) == 0);
            @(posedge clk);
            #1;
            cyc++;
            if (done) fin = 1;
        end
        start = 1'b0;
        if (!fin) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout: got no done after %0d cycles, want %0d", cyc, RUN);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_ab_cin"}, int'({a, b, cin}), 0);
        check_val({tag, "_busy"}, int'(busy), 0);
        check_val({tag, "_done"}, int'(done), 0);
        check_val({tag, "_pass"}, int'(pass), 0);
        check_val({tag, "_fail_count"}, int'(fail_count), 0);
        check_val({tag, "_first_fail"}, int'(first_fail_idx), 0);
    endtask

    initial begin
        int cyc, exp_fails, exp_first, hold;
        foreach (err_mask[i]) err_mask[i] = 5'd0;

        // Reset state.
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_val("idle_busy", int'(busy), 0);

        // Correct adder; aux instances run alongside.
        fault_mode = 0;
        run_once(1, 0, 1, cyc);
        check_val("run1_cycles", cyc, RUN);
        check_val("run1_pass", int'(pass), 1);
        check_val("run1_fail_count", int'(fail_count), 0);
        check_val("w1_fail_count", int'(fc1), 4);
        check_val("w1_first_fail", int'(ffi1), 3);
        check_val("w1_pass_busy", int'({pass1, busy1, done1}), 1);
        check_val("f4_fail_count", int'(fc2), 15);
        check_val("f4_first_fail", int'(ffi2), 1);
        check_val("f4_pass_busy", int'({pass2, busy2, done2}), 1);

        // Sum bit0 stuck-at-0, start held as a level and poked mid-run.
        fault_mode = 1;
        run_once(3, 1, 0, cyc);
        check_val("run2_cycles", cyc, RUN);
        check_val("run2_fail_count", int'(fail_count), 256);
        check_val("run2_first_fail", int'(first_fail_idx), 1);
        check_val("run2_pass", int'(pass), 0);
        check_val("model_fails_pin", m_fails, 256);

        // Random fault patterns.
        fault_mode = 2;
        for (int r = 0; r < 3; r++) begin
            exp_fails = 0;
            exp_first = 0;
            for (int v = 0; v < N; v++) begin
                err_mask[v] = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
                if (err_mask[v] != 5'd0) begin
                    if (exp_fails == 0) exp_first = v;
                    exp_fails++;
                end
            end
            hold = int'($urandom_range(1, 3));
            run_once(hold, 1, 0, cyc);
            check_val("rand_cycles", cyc, RUN);
            check_val("rand_fail_count", int'(fail_count), exp_fails);
            check_val("rand_first_fail", int'(first_fail_idx), exp_first);
            check_val("rand_pass", int'(pass), int'(exp_fails == 0));
        end

        // Reset mid-run, then a clean fresh run.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat ($urandom_range(100, 900)) @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_val("post_rst_idle_busy", int'(busy), 0);
        check_val("post_rst_idle_done", int'(done), 0);
        fault_mode = 0;
        run_once(1, 0, 0, cyc);
        check_val("fresh_cycles", cyc, RUN);
        check_val("fresh_pass", int'(pass), 1);
        check_val("fresh_vector_hold", int'({a, b, cin}), N - 1);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
